waveform_uart_streamer: RTL and testbench

Reads a captured ADC waveform out of the 500-entry capture buffer and serializes it as a framed byte stream for the UART transmitter. Sits between the trigger/capture logic, which fills the buffer and pulses `start` when a capture is complete, and the UART TX byte interface. Each frame is: header byte, two bytes per 14-bit sample, then an 8-bit checksum.

---
 rtl/waveform_uart_streamer_if.sv | 22 ++
 rtl/waveform_uart_streamer.sv | 116 +++++++++++
 tb/tb_waveform_uart_streamer.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/waveform_uart_streamer_if.sv
// Capture-buffer read port, UART TX byte handshake and frame control for the
// waveform streamer. master = streamer side, slave = buffer/UART/trigger side.
interface waveform_uart_streamer_if;
  logic        start;
  logic [8:0]  rd_addr;
  logic [13:0] rd_data;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        busy;
  logic        done;

  modport master (
    input  start, rd_data, tx_ready,
    output rd_addr, tx_data, tx_valid, busy, done
  );

  modport slave (
    output start, rd_data, tx_ready,
    input  rd_addr, tx_data, tx_valid, busy, done
  );
endinterface

// File: rtl/waveform_uart_streamer.sv
// Streams the capture buffer to the UART TX as: header, {hi,lo} per 14-bit
// sample, then an 8-bit additive checksum of the sample bytes.
module waveform_uart_streamer #(
  parameter int unsigned NUM_SAMPLES = 500,
  parameter logic [7:0]  HEADER      = 8'hA5
) (
  input  logic                     clk,
  input  logic                     reset_n,
  waveform_uart_streamer_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEADER,
    S_FETCH,
    S_WAIT_RD,
    S_SEND_HI,
    S_SEND_LO,
    S_CHECKSUM,
    S_DONE
  } state_t;

  localparam logic [8:0] LAST_ADDR = 9'(NUM_SAMPLES - 1);

  state_t      state, state_nxt;
  logic [8:0]  counter, counter_nxt;
  logic [7:0]  checksum, checksum_nxt;
  logic [13:0] sample, sample_nxt;
  logic [7:0]  tx_byte;
  logic        tx_fire;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      counter  <= '0;
      checksum <= '0;
      sample   <= '0;
    end else begin
      state    <= state_nxt;
      counter  <= counter_nxt;
      checksum <= checksum_nxt;
      sample   <= sample_nxt;
    end
  end

  // Outputs decode from the registered state only, so an asserted reset
  // forces them to their idle values without waiting for a clock.
  always_comb begin
    state_nxt    = state;
    counter_nxt  = counter;
    checksum_nxt = checksum;
    sample_nxt   = sample;
    tx_byte      = '0;
    bus.tx_valid = 1'b0;
    bus.done     = 1'b0;
    tx_fire      = 1'b0;

    case (state)
      S_IDLE: begin
        if (bus.start) begin
          counter_nxt  = '0;
          checksum_nxt = '0;
          state_nxt    = S_HEADER;
        end
      end
      S_HEADER: begin
        tx_byte      = HEADER;
        bus.tx_valid = 1'b1;
        if (bus.tx_ready) state_nxt = S_FETCH;
      end
      S_FETCH: begin
        state_nxt = S_WAIT_RD;
      end
      S_WAIT_RD: begin
        sample_nxt = bus.rd_data;
        state_nxt  = S_SEND_HI;
      end
      S_SEND_HI: begin
        tx_byte      = {2'b00, sample[13:8]};
        bus.tx_valid = 1'b1;
        tx_fire      = bus.tx_ready;
        if (tx_fire) state_nxt = S_SEND_LO;
      end
      S_SEND_LO: begin
        tx_byte      = sample[7:0];
        bus.tx_valid = 1'b1;
        tx_fire      = bus.tx_ready;
        if (tx_fire) begin
          if (counter == LAST_ADDR) begin
            state_nxt = S_CHECKSUM;
          end else begin
            counter_nxt = counter + 9'd1;
            state_nxt   = S_FETCH;
          end
        end
      end
      S_CHECKSUM: begin
        tx_byte      = checksum;
        bus.tx_valid = 1'b1;
        if (bus.tx_ready) state_nxt = S_DONE;
      end
      S_DONE: begin
        bus.done  = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase

    if (tx_fire) checksum_nxt = checksum + tx_byte;
  end

  assign bus.tx_data = tx_byte;
  assign bus.rd_addr = counter;
  assign bus.busy    = (state != S_IDLE) && (state != S_DONE);

endmodule

// File: tb/tb_waveform_uart_streamer.sv
// Directed bench for waveform_uart_streamer: table of whole-frame vectors plus
// hand-written start-hold and mid-frame reset sequences.
module tb_waveform_uart_streamer;

  localparam int NS = 500;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  waveform_uart_streamer_if bus ();

  waveform_uart_streamer #(.NUM_SAMPLES(NS), .HEADER(8'hA5)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int compared = 0;
  int mismatched = 0;

  task automatic chk(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Buffer model: registered read; anything outside the FETCH/WAIT_RD window
  // returns a poison word so a mistimed capture corrupts the byte stream.
  logic [13:0] mem [NS];
  logic [13:0] rd_q;
  always @(posedge clk) rd_q <= mem[bus.rd_addr];
  assign bus.rd_data = (bus.busy && !bus.tx_valid) ? rd_q : 14'h2AAA;

  task automatic fill(input int pattern);
    for (int i = 0; i < NS; i++) mem[i] = (pattern == 0) ? 14'(i) : 14'h3FFF;
  endtask

  bit rand_mode = 1'b0;
  initial begin
    bus.tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.tx_ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  logic [7:0] cap[$];
  int         addrs[$];
  int         last_addr = -1;
  int         stalls = 0;
  int         stall_err = 0;
  int         done_seen = 0;
  bit         prev_stall = 1'b0;
  logic [7:0] prev_data = '0;

  always @(negedge clk) begin
    if (prev_stall && !(bus.tx_valid && bus.tx_data == prev_data)) stall_err++;
    prev_stall = bus.tx_valid && !bus.tx_ready;
    prev_data  = bus.tx_data;
    if (bus.tx_valid && !bus.tx_ready) stalls++;
    if (bus.tx_valid && bus.tx_ready) cap.push_back(bus.tx_data);
    if (bus.busy && !bus.tx_valid && int'(bus.rd_addr) != last_addr) begin
      addrs.push_back(int'(bus.rd_addr));
      last_addr = int'(bus.rd_addr);
    end
    if (bus.done) done_seen++;
  end

  task automatic clear_logs();
    cap.delete();
    addrs.delete();
    last_addr = -1;
    stalls    = 0;
    stall_err = 0;
  endtask

  // Pulse (or hold) start and count edges until done, bounded.
  task automatic run_frame(input bit hold, output int n);
    clear_logs();
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    @(posedge clk);
    n = 1;
    #1;
    if (!hold) bus.start = 1'b0;
    while (!bus.done && n < 20000) begin
      @(posedge clk);
      n++;
      #1;
    end
    chk("done_reached", int'(bus.done), 1);
  endtask

  task automatic check_frame(input logic [7:0] exp_ck, input int n);
    logic [7:0] exp_bytes[$];
    logic [7:0] sum;
    int bad, first_bad, addr_bad;
    sum = '0;
    exp_bytes.push_back(8'hA5);
    for (int i = 0; i < NS; i++) begin
      logic [13:0] s;
      s = mem[i];
      exp_bytes.push_back({2'b00, s[13:8]});
      exp_bytes.push_back(s[7:0]);
      sum = sum + {2'b00, s[13:8]} + s[7:0];
    end
    exp_bytes.push_back(sum);
    chk("byte_count", cap.size(), 2 * NS + 2);
    bad = 0;
    first_bad = -1;
    for (int i = 0; i < cap.size() && i < exp_bytes.size(); i++)
      if (cap[i] !== exp_bytes[i]) begin
        bad++;
        if (first_bad < 0) first_bad = i;
      end
    if (bad != 0) $display("  first bad byte index %0d", first_bad);
    chk("byte_mismatches", bad, 0);
    if (cap.size() > 0) chk("checksum_byte", int'(cap[cap.size() - 1]), int'(exp_ck));
    chk("done_latency", n, 2003 + stalls);
    chk("addr_count", addrs.size(), NS);
    addr_bad = 0;
    for (int i = 0; i < addrs.size(); i++) if (addrs[i] != i) addr_bad++;
    chk("addr_order_errors", addr_bad, 0);
    chk("stall_hold_errors", stall_err, 0);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_rd_addr"}, int'(bus.rd_addr), 0);
    chk({tag, "_tx_data"}, int'(bus.tx_data), 0);
    chk({tag, "_tx_valid"}, int'(bus.tx_valid), 0);
    chk({tag, "_busy"}, int'(bus.busy), 0);
    chk({tag, "_done"}, int'(bus.done), 0);
  endtask

  typedef struct {
    int         pattern;
    bit         rnd;
    logic [7:0] exp_ck;
  } vec_t;

  initial begin
    vec_t vecs[3];
    int n, d0;
    vecs[0] = '{pattern: 0, rnd: 1'b0, exp_ck: 8'h42};
    vecs[1] = '{pattern: 1, rnd: 1'b0, exp_ck: 8'h18};
    vecs[2] = '{pattern: 0, rnd: 1'b1, exp_ck: 8'h42};

    bus.start = 1'b0;
    fill(0);
    repeat (3) @(posedge clk);
    #1;
    chk_idle_outputs("reset");
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_idle_outputs("idle");

    for (int v = 0; v < 3; v++) begin
      fill(vecs[v].pattern);
      rand_mode = vecs[v].rnd;
      run_frame(1'b0, n);
      check_frame(vecs[v].exp_ck, n);
      rand_mode = 1'b0;
      repeat (3) @(posedge clk);
    end

    // start held through the frame: one frame, next begins only via IDLE
    fill(0);
    run_frame(1'b1, n);
    check_frame(8'h42, n);
    chk("hold_done_busy", int'(bus.busy), 0);
    @(posedge clk);
    #1;
    chk("hold_idle_valid", int'(bus.tx_valid), 0);
    chk("hold_idle_busy", int'(bus.busy), 0);
    chk("hold_bytes_after_done", cap.size(), 2 * NS + 2);
    @(posedge clk);
    #1;
    chk("hold_restart_valid", int'(bus.tx_valid), 1);
    chk("hold_restart_header", int'(bus.tx_data), 8'hA5);
    bus.start = 1'b0;
    reset_n = 1'b0;
    #1;
    chk_idle_outputs("hold_abort");
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (2) @(posedge clk);

    // reset during SEND_LO of sample 10
    clear_logs();
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    n = 0;
    while (cap.size() < 22 && n < 1000) begin
      @(posedge clk);
      n++;
      #1;
    end
    chk("midreset_reached", cap.size(), 22);
    chk("midreset_lo_byte", int'(bus.tx_data), 10);
    d0 = done_seen;
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk_idle_outputs("midreset");
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("midreset_no_done", done_seen, d0);
    chk("midreset_busy", int'(bus.busy), 0);
    run_frame(1'b0, n);
    check_frame(8'h42, n);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
